// File: rtl/snake_pkg.sv
// Shared types for the snake game controller: direction codes, FSM state encoding and direction helper.
package snake_pkg;

  localparam int DIR_W = 2;

  typedef enum logic [DIR_W-1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  // The encoding is chosen so that the reverse of any heading is its bitwise complement.
  function automatic logic [DIR_W-1:0] dir_opposite(input logic [DIR_W-1:0] d);
    return ~d;
  endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Move-tick down-counter: load presets period-1, hold freezes, zero_o flags the cycle the count expires.
// zero_o is combinational; the counter reloads from period on that same edge so a new period applies at the next reload.
module snake_tick_gen #(
  parameter int WIDTH = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] period,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    zero_o = 1'b0;
    if (load) begin
      cnt_d = period - WIDTH'(1);
    end else if (en) begin
      if (cnt_q == '0) begin
        zero_o = 1'b1;
        cnt_d  = period - WIDTH'(1);
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: FSM, move tick, direction filter and score; all outputs registered (input at N -> effect at N+1).
// Build option SNAKE_CTRL_SPEEDUP_EN: each scored point shortens the move period by TICK_STEP down to TICK_MIN.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int TICK_PERIOD     = 25_000_000,
  parameter int TICK_WIDTH      = 25,
  parameter int TICK_MIN        = 6_250_000,
  parameter int TICK_STEP       = 1_000_000,
  parameter int INIT_CYCLES     = 4,
  parameter int SCORE_WIDTH     = 8,
  parameter int DIRECTION_WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       btn_start,
  input  logic                       btn_pause,
  input  logic                       btn_dir_vld,
  input  logic [DIRECTION_WIDTH-1:0] btn_dir,
  input  logic                       snake_score,
  input  logic                       snake_lose,
  output logic                       snake_rst,
  output logic                       snake_enb,
  output logic                       snake_valid,
  output logic [DIRECTION_WIDTH-1:0] snake_direction,
  output logic [SCORE_WIDTH-1:0]     score,
  output logic [2:0]                 game_state,
  output logic                       game_over
);

`ifdef SNAKE_CTRL_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  localparam int ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [TICK_WIDTH-1:0] PERIOD_V = TICK_WIDTH'(TICK_PERIOD);
  localparam logic [TICK_WIDTH-1:0] MIN_V    = TICK_WIDTH'(TICK_MIN);
  localparam logic [TICK_WIDTH-1:0] STEP_V   = TICK_WIDTH'(TICK_STEP);
  localparam logic [DIRECTION_WIDTH-1:0] RIGHT_V = DIRECTION_WIDTH'(DIR_RIGHT);

  state_e                     state_q, state_d;
  logic [ICW-1:0]             init_cnt_q, init_cnt_d;
  logic [TICK_WIDTH-1:0]      period_q, period_d;
  logic [DIRECTION_WIDTH-1:0] committed_q, committed_d;
  logic [DIRECTION_WIDTH-1:0] pending_q, pending_d;
  logic [SCORE_WIDTH-1:0]     score_q, score_d;
  logic                       snake_rst_q, snake_rst_d;
  logic                       snake_enb_q, snake_enb_d;
  logic                       snake_valid_q, snake_valid_d;
  logic                       game_over_q, game_over_d;
  logic                       tick_en, tick_load, tick;
  logic                       point;

  // The edge that leaves RUN is not counted, so a pause keeps exactly the cycles already run.
  assign tick_en   = (state_q == ST_RUN) && (state_d == ST_RUN);
  assign tick_load = (state_q == ST_INIT);
  assign point     = (state_q == ST_RUN) && snake_score;

  snake_tick_gen #(.WIDTH(TICK_WIDTH)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .load   (tick_load),
    .en     (tick_en),
    .period (period_q),
    .zero_o (tick)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (btn_start) state_d = ST_INIT;
      ST_INIT:  if (init_cnt_q == ICW'(INIT_CYCLES - 1)) state_d = ST_RUN;
      ST_RUN: begin
        if (snake_lose)     state_d = ST_OVER;
        else if (btn_pause) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (btn_start)      state_d = ST_INIT;
        else if (btn_pause) state_d = ST_RUN;
      end
      ST_OVER:  if (btn_start) state_d = ST_INIT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    init_cnt_d  = (state_q == ST_INIT) ? init_cnt_q + ICW'(1) : '0;
    committed_d = committed_q;
    pending_d   = pending_q;
    score_d     = score_q;
    period_d    = period_q;
    if (state_d == ST_INIT && state_q != ST_INIT) begin
      committed_d = RIGHT_V;
      pending_d   = RIGHT_V;
      score_d     = '0;
      period_d    = PERIOD_V;
    end else begin
      if (tick) committed_d = pending_q;
      // A request racing the tick is judged against the heading being committed on that tick.
      if ((state_q == ST_RUN) && btn_dir_vld && (btn_dir != dir_opposite(committed_d)))
        pending_d = btn_dir;
      if (point && (score_q != '1)) score_d = score_q + SCORE_WIDTH'(1);
      if (SPEEDUP && point)
        period_d = (period_q >= MIN_V + STEP_V) ? period_q - STEP_V : MIN_V;
    end
    snake_rst_d   = (state_d == ST_INIT) && (state_q != ST_INIT);
    snake_enb_d   = (state_d == ST_RUN);
    game_over_d   = (state_d == ST_OVER);
    snake_valid_d = tick;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      init_cnt_q    <= '0;
      period_q      <= PERIOD_V;
      committed_q   <= RIGHT_V;
      pending_q     <= RIGHT_V;
      score_q       <= '0;
      snake_rst_q   <= 1'b1;
      snake_enb_q   <= 1'b0;
      snake_valid_q <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      period_q      <= period_d;
      committed_q   <= committed_d;
      pending_q     <= pending_d;
      score_q       <= score_d;
      snake_rst_q   <= snake_rst_d;
      snake_enb_q   <= snake_enb_d;
      snake_valid_q <= snake_valid_d;
      game_over_q   <= game_over_d;
    end
  end

  assign snake_rst       = snake_rst_q;
  assign snake_enb       = snake_enb_q;
  assign snake_valid     = snake_valid_q;
  assign snake_direction = committed_q;
  assign score           = score_q;
  assign game_state      = state_q;
  assign game_over       = game_over_q;

endmodule
